// File: rtl/alu.sv
// Integer ALU for the execute stage: ALUOut/Zero/less combinational, plus registered copies.
// Latency: combinational outputs 0 cycles; _r outputs 1 cycle after the inputs are applied.
// Backpressure: none; no handshake, the registered copy updates on every rising edge.
module alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      ALUControl,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [XLEN-1:0] ALUOut,
  output logic            Zero,
  output logic            less,
  output logic [XLEN-1:0] ALUOut_r,
  output logic            Zero_r,
  output logic            less_r
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  // Only the low bits of B select the shift distance; the rest are ignored.
  logic [SHW-1:0] shamt;
  logic           lt_signed;
  logic           lt_unsigned;
  logic [XLEN-1:0] alu_res;

  assign shamt       = B[SHW-1:0];
  assign lt_signed   = ($signed(A) < $signed(B));
  assign lt_unsigned = (A < B);

  // Result mux; unused codes fall to zero so Zero reads 1 and nothing goes X.
  always_comb begin
    alu_res = '0;
    case (ALUControl)
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_signed};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_unsigned};
      OP_SRL:  alu_res = A >> shamt;
      OP_SRA:  alu_res = $signed(A) >>> shamt;
      OP_SLL:  alu_res = A << shamt;
      default: alu_res = '0;
    endcase
  end

  // The comparison flag is signed only for SLT; every other code, including
  // SLTU and the unused codes, reports the unsigned comparison.
  always_comb begin
    less = lt_unsigned;
    if (ALUControl == OP_SLT) begin
      less = lt_signed;
    end
  end

  assign ALUOut = alu_res;
  assign Zero   = (alu_res == '0);

  // Registered copy for pipelined consumers; reset clears only these outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ALUOut_r <= '0;
      Zero_r   <= 1'b0;
      less_r   <= 1'b0;
    end else begin
      ALUOut_r <= ALUOut;
      Zero_r   <= Zero;
      less_r   <= less;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors push expected results into queues,
// independent monitors pop and compare combinational outputs on the falling edge
// and registered outputs on the falling edge of the cycle they are due.
module tb_alu;

  typedef struct {
    logic [31:0] out;
    logic        zero;
    logic        less;
    int          due;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ALUControl = 4'b0000;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] ALUOut;
  logic        Zero;
  logic        less;
  logic [31:0] ALUOut_r;
  logic        Zero_r;
  logic        less_r;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   vec_id = 0;
  exp_t comb_q[$];
  exp_t reg_q[$];

  alu #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ALUControl (ALUControl),
    .A          (A),
    .B          (B),
    .ALUOut     (ALUOut),
    .Zero       (Zero),
    .less       (less),
    .ALUOut_r   (ALUOut_r),
    .Zero_r     (Zero_r),
    .less_r     (less_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec%0d: got 0x%08h expected 0x%08h", name, id, act, exp);
    end
  endtask

  // Drive one vector right after the rising edge; the registered result is due
  // after the next rising edge (zeros if reset is held on that edge).
  task automatic apply(input logic rst_v, input logic [3:0] ctrl, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e_out,
                       input logic e_zero, input logic e_less);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = rst_v;
    ALUControl = ctrl;
    A          = a;
    B          = b;
    e.out  = e_out;
    e.zero = e_zero;
    e.less = e_less;
    e.due  = cyc + 1;
    e.id   = vec_id;
    comb_q.push_back(e);
    if (rst_v) begin
      e.out  = '0;
      e.zero = 1'b0;
      e.less = 1'b0;
    end
    reg_q.push_back(e);
    vec_id++;
  endtask

  // Combinational monitor
  always @(negedge clk) begin
    if (comb_q.size() > 0) begin
      exp_t e;
      e = comb_q.pop_front();
      chk("ALUOut", e.id, ALUOut, e.out);
      chk("Zero",   e.id, {31'b0, Zero}, {31'b0, e.zero});
      chk("less",   e.id, {31'b0, less}, {31'b0, e.less});
    end
  end

  // Registered monitor: by this falling edge the inputs have already moved on,
  // so a match also shows the _r outputs held across the mid-cycle change.
  always @(negedge clk) begin
    if (reg_q.size() > 0 && reg_q[0].due == cyc) begin
      exp_t e;
      e = reg_q.pop_front();
      chk("ALUOut_r", e.id, ALUOut_r, e.out);
      chk("Zero_r",   e.id, {31'b0, Zero_r}, {31'b0, e.zero});
      chk("less_r",   e.id, {31'b0, less_r}, {31'b0, e.less});
    end
  end

  initial begin
    int waited;
    // rst  ctrl     A             B             ALUOut        Z     less
    apply(1'b1, 4'b0000, 32'd10,       32'd5,        32'd15,       1'b0, 1'b0); // reset edge, comb still live
    apply(1'b0, 4'b0000, 32'd10,       32'd5,        32'd15,       1'b0, 1'b0); // ADD
    apply(1'b0, 4'b0001, 32'd10,       32'd5,        32'd5,        1'b0, 1'b0); // SUB
    apply(1'b0, 4'b0010, 32'd10,       32'd5,        32'd0,        1'b1, 1'b0); // AND
    apply(1'b0, 4'b0011, 32'd10,       32'd5,        32'd15,       1'b0, 1'b0); // OR
    apply(1'b0, 4'b0100, 32'd10,       32'd5,        32'd15,       1'b0, 1'b0); // XOR
    apply(1'b0, 4'b0001, 32'd7,        32'd7,        32'd0,        1'b1, 1'b0); // SUB equal
    apply(1'b0, 4'b0101, 32'hFFFFFFFD, 32'd5,        32'd1,        1'b0, 1'b1); // SLT -3<5
    apply(1'b0, 4'b1001, 32'hFFFFFFFD, 32'd5,        32'd0,        1'b1, 1'b0); // SLTU
    apply(1'b0, 4'b0101, 32'd5,        32'hFFFFFFFD, 32'd0,        1'b1, 1'b0); // SLT 5<-3 false
    apply(1'b0, 4'b0110, 32'h400,      32'd3,        32'h80,       1'b0, 1'b0); // SRL
    apply(1'b0, 4'b0111, 32'hFFFFFFF0, 32'd2,        32'hFFFFFFFC, 1'b0, 1'b0); // SRA
    apply(1'b0, 4'b1000, 32'd3,        32'd4,        32'd48,       1'b0, 1'b1); // SLL
    apply(1'b0, 4'b1000, 32'd1,        32'd33,       32'd2,        1'b0, 1'b1); // SLL shamt masked
    apply(1'b0, 4'b0111, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0); // SRA max shift
    apply(1'b0, 4'b0110, 32'h80000000, 32'd31,       32'd1,        1'b0, 1'b0); // SRL max shift
    apply(1'b0, 4'b0000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0); // ADD wraps
    apply(1'b0, 4'b1111, 32'd10,       32'd5,        32'd0,        1'b1, 1'b0); // unused
    apply(1'b0, 4'b1010, 32'd3,        32'd9,        32'd0,        1'b1, 1'b1); // unused, unsigned less
    apply(1'b1, 4'b0001, 32'd1,        32'd2,        32'hFFFFFFFF, 1'b0, 1'b1); // re-reset
    apply(1'b0, 4'b0000, 32'd10,       32'd5,        32'd15,       1'b0, 1'b0); // ADD after reset
    apply(1'b0, 4'b0011, 32'd0,        32'd0,        32'd0,        1'b1, 1'b0); // OR of zeros

    waited = 0;
    while ((comb_q.size() > 0 || reg_q.size() > 0) && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    tests++;
    if (comb_q.size() > 0 || reg_q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d comb and %0d reg expectations left, required 0", comb_q.size(), reg_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
